vga_timing_ctrl: RTL and testbench

- Master raster sequencer for the display path.
- Divides pixel_clk into a pixel-enable strobe (count) and runs the horizontal and vertical counters for 640x480@60 (800x525 totals).
- Produces hsync, vsync and blank, plus the playfield-window flag and frame/vblank event pulses that the game logic uses to schedule sprite and maze updates.
- Feeds hcounter, vcounter, blank and count directly into the pixel output stage.

---
 rtl/vga_timing_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: master raster sequencer for the display path.
// Divides pixel_clk into a pixel-enable strobe, runs the horizontal and vertical
// counters, and produces syncs, blank, the playfield window flag and frame /
// vblank event pulses. Every decoded output is registered from the next-state
// counter values so it changes on the same edge as hcounter/vcounter.
module vga_timing_ctrl #(
    parameter int unsigned DIV      = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PF_X0    = 192,
    parameter int unsigned PF_X1    = 448,
    parameter int unsigned PF_Y0    = 48,
    parameter int unsigned PF_Y1    = 432
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        enable,
    output logic        count,
    output logic [10:0] hcounter,
    output logic [10:0] vcounter,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        playfield,
    output logic        frame_start,
    output logic        vblank_start
);

    localparam int unsigned CW = 11;
    localparam int unsigned DW = 4;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    localparam logic [CW-1:0] H_FP_START = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SY_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_BP_START = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST     = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    localparam logic [CW-1:0] V_FP_START = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SY_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_BP_START = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [CW-1:0] PF_X0_C = CW'(PF_X0);
    localparam logic [CW-1:0] PF_X1_C = CW'(PF_X1);
    localparam logic [CW-1:0] PF_Y0_C = CW'(PF_Y0);
    localparam logic [CW-1:0] PF_Y1_C = CW'(PF_Y1);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    logic [DW-1:0] div_q,   div_d;
    logic          count_q, count_d;
    logic [CW-1:0] hcnt_q,  hcnt_d;
    logic [CW-1:0] vcnt_q,  vcnt_d;
    logic          line_wrap;
    phase_e        hph_q,   hph_d;
    phase_e        vph_q,   vph_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic          pf_q,    pf_d;
    logic          fs_q,    fs_d;
    logic          vbs_q,   vbs_d;

    // Pixel divider: strobe lags the divider so the first strobe lands DIV cycles after enable.
    always_comb begin
        div_d   = '0;
        count_d = 1'b0;
        if (enable) begin
            div_d   = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
            count_d = (div_q == DIV_LAST);
        end
    end

    // Raster counters: advance on strobe, park at (0,0) while disabled.
    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        line_wrap = 1'b0;
        if (!enable) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (count_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d    = '0;
                line_wrap = 1'b1;
                vcnt_d    = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
            end else begin
                hcnt_d = hcnt_q + CW'(1);
            end
        end
    end

    // Horizontal phase next-state, stepped at the column boundaries.
    always_comb begin
        hph_d = hph_q;
        if (!enable) begin
            hph_d = PH_ACTIVE;
        end else if (count_q) begin
            case (hph_q)
                PH_ACTIVE: if (hcnt_d == H_FP_START) hph_d = PH_FRONT;
                PH_FRONT:  if (hcnt_d == H_SY_START) hph_d = PH_SYNC;
                PH_SYNC:   if (hcnt_d == H_BP_START) hph_d = PH_BACK;
                PH_BACK:   if (hcnt_d == '0)         hph_d = PH_ACTIVE;
                default:                             hph_d = PH_ACTIVE;
            endcase
        end
    end

    // Vertical phase next-state, stepped only on line wrap.
    always_comb begin
        vph_d = vph_q;
        if (!enable) begin
            vph_d = PH_ACTIVE;
        end else if (line_wrap) begin
            case (vph_q)
                PH_ACTIVE: if (vcnt_d == V_FP_START) vph_d = PH_FRONT;
                PH_FRONT:  if (vcnt_d == V_SY_START) vph_d = PH_SYNC;
                PH_SYNC:   if (vcnt_d == V_BP_START) vph_d = PH_BACK;
                PH_BACK:   if (vcnt_d == '0)         vph_d = PH_ACTIVE;
                default:                             vph_d = PH_ACTIVE;
            endcase
        end
    end

    // Decoded outputs from next-state counters/phases for zero skew against the counters.
    always_comb begin
        hsync_d = (hph_d != PH_SYNC);
        vsync_d = (vph_d != PH_SYNC);
        blank_d = 1'b1;
        pf_d    = 1'b0;
        fs_d    = 1'b0;
        vbs_d   = 1'b0;
        if (enable) begin
            blank_d = (hcnt_d >= H_FP_START) || (vcnt_d >= V_FP_START);
            pf_d    = (hcnt_d >= PF_X0_C) && (hcnt_d < PF_X1_C) &&
                      (vcnt_d >= PF_Y0_C) && (vcnt_d < PF_Y1_C);
            fs_d    = count_q && (hcnt_d == '0) && (vcnt_d == '0);
            vbs_d   = count_q && (hcnt_d == '0) && (vcnt_d == V_FP_START);
        end
    end

    // Divider, counters and phase state registers.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            count_q <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hph_q   <= PH_ACTIVE;
            vph_q   <= PH_ACTIVE;
        end else begin
            div_q   <= div_d;
            count_q <= count_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hph_q   <= hph_d;
            vph_q   <= vph_d;
        end
    end

    // Registered sync, window and event outputs.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b1;
            pf_q    <= 1'b0;
            fs_q    <= 1'b0;
            vbs_q   <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            pf_q    <= pf_d;
            fs_q    <= fs_d;
            vbs_q   <= vbs_d;
        end
    end

    assign count        = count_q;
    assign hcounter     = hcnt_q;
    assign vcounter     = vcnt_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign blank        = blank_q;
    assign playfield    = pf_q;
    assign frame_start  = fs_q;
    assign vblank_start = vbs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks of vga_timing_ctrl. Instance a uses the
// 640x480 defaults for divider/line/enable behaviour; instance b uses a shrunken
// raster (24x19 totals, DIV=1) so full frames, the window and vsync fit in a short run.
module tb_vga_timing_ctrl;

    logic        clk;
    logic        rst_a, en_a, rst_b, en_b;

    logic        a_count, a_hsync, a_vsync, a_blank, a_pf, a_fs, a_vbs;
    logic [10:0] a_h, a_v;
    logic        b_count, b_hsync, b_vsync, b_blank, b_pf, b_fs, b_vbs;
    logic [10:0] b_h, b_v;

    int n_checks = 0;
    int n_fail   = 0;

    vga_timing_ctrl dut_a (
        .pixel_clk   (clk),
        .reset       (rst_a),
        .enable      (en_a),
        .count       (a_count),
        .hcounter    (a_h),
        .vcounter    (a_v),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .blank       (a_blank),
        .playfield   (a_pf),
        .frame_start (a_fs),
        .vblank_start(a_vbs)
    );

    vga_timing_ctrl #(
        .DIV(1),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PF_X0(4), .PF_X1(12), .PF_Y0(2), .PF_Y1(10)
    ) dut_b (
        .pixel_clk   (clk),
        .reset       (rst_b),
        .enable      (en_b),
        .count       (b_count),
        .hcounter    (b_h),
        .vcounter    (b_v),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .blank       (b_blank),
        .playfield   (b_pf),
        .frame_start (b_fs),
        .vblank_start(b_vbs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int found;
    int hs_strobes, hs_min, hs_max, bl_min, bl_max, align_errs, pulse_errs;
    int wrap_prev_h, wrap_h, prev_h, prev_v, fs_seen;
    int fs_n, strobes, vbs_n, vbs_h, vbs_v, vs_min, vs_max, vs_err;
    int fs_pre_h, fs_pre_v, fs_h, fs_v;
    logic pf_p0, pf_p1, pf_n0, pf_n1, pf_n2;

    initial begin
        rst_a = 1'b0; en_a = 1'b1;
        rst_b = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check_eq("rst_count", 32'(a_count), 0);
        check_eq("rst_h", 32'(a_h), 0);
        check_eq("rst_v", 32'(a_v), 0);
        check_eq("rst_hsync", 32'(a_hsync), 1);
        check_eq("rst_vsync", 32'(a_vsync), 1);
        check_eq("rst_blank", 32'(a_blank), 1);
        check_eq("rst_pf", 32'(a_pf), 0);
        check_eq("rst_fs", 32'(a_fs), 0);
        check_eq("rst_vbs", 32'(a_vbs), 0);

        // divider start-up with DIV=2
        rst_a = 1'b1;
        @(negedge clk); check_eq("div_c1", 32'(a_count), 0);
        @(negedge clk); check_eq("div_c2", 32'(a_count), 1);
                        check_eq("div_h_before", 32'(a_h), 0);
        @(negedge clk); check_eq("div_c3", 32'(a_count), 0);
                        check_eq("div_h_after", 32'(a_h), 1);
                        check_eq("div_blank_active", 32'(a_blank), 0);
        @(negedge clk); check_eq("div_c4", 32'(a_count), 1);

        // line 0 scan up to the wrap into line 1
        found = 0; hs_strobes = 0; hs_min = 9999; hs_max = 0;
        bl_min = 9999; bl_max = 0; align_errs = 0; pulse_errs = 0;
        prev_h = 32'(a_h); wrap_prev_h = -1; wrap_h = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (a_v == 11'd1) begin
                found = 1; wrap_prev_h = prev_h; wrap_h = 32'(a_h);
                break;
            end
            if (!a_hsync) begin
                if (a_count) hs_strobes++;
                if (32'(a_h) < hs_min) hs_min = 32'(a_h);
                if (32'(a_h) > hs_max) hs_max = 32'(a_h);
            end
            if (a_blank) begin
                if (32'(a_h) < bl_min) bl_min = 32'(a_h);
                if (32'(a_h) > bl_max) bl_max = 32'(a_h);
            end
            if (a_hsync !== !(a_h >= 11'd656 && a_h <= 11'd751)) align_errs++;
            if (a_blank !== (a_h >= 11'd640)) align_errs++;
            if (a_pf !== 1'b0 || a_vsync !== 1'b1) align_errs++;
            if (a_fs || a_vbs) pulse_errs++;
            prev_h = 32'(a_h);
        end
        check_eq("line_wrap_seen", found, 1);
        check_eq("line_wrap_prev_h", wrap_prev_h, 799);
        check_eq("line_wrap_h", wrap_h, 0);
        check_eq("hsync_strobes", hs_strobes, 96);
        check_eq("hsync_first_col", hs_min, 656);
        check_eq("hsync_last_col", hs_max, 751);
        check_eq("blank_first_col", bl_min, 640);
        check_eq("blank_last_col", bl_max, 799);
        check_eq("line_align_errs", align_errs, 0);
        check_eq("line_pulse_errs", pulse_errs, 0);

        // drop enable at hcounter=300 of line 1
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (a_h == 11'd300) begin found = 1; break; end
        end
        check_eq("reach_h300", found, 1);
        en_a = 1'b0;
        @(negedge clk);
        check_eq("park_h", 32'(a_h), 0);
        check_eq("park_v", 32'(a_v), 0);
        check_eq("park_blank", 32'(a_blank), 1);
        check_eq("park_hsync", 32'(a_hsync), 1);
        check_eq("park_vsync", 32'(a_vsync), 1);
        check_eq("park_count", 32'(a_count), 0);
        check_eq("park_fs", 32'(a_fs), 0);
        repeat (3) @(negedge clk);
        check_eq("park_hold_h", 32'(a_h), 0);
        check_eq("park_hold_count", 32'(a_count), 0);

        // re-enable: first strobe after two cycles, no frame_start for parked (0,0)
        en_a = 1'b1; fs_seen = 0;
        @(negedge clk); check_eq("reen_c1", 32'(a_count), 0); fs_seen += 32'(a_fs);
        @(negedge clk); check_eq("reen_c2", 32'(a_count), 1); fs_seen += 32'(a_fs);
                        check_eq("reen_h_before", 32'(a_h), 0);
        @(negedge clk); check_eq("reen_h_after", 32'(a_h), 1); fs_seen += 32'(a_fs);
        check_eq("reen_no_fs", fs_seen, 0);

        // shrunken raster: full-frame checks
        en_b = 1'b1;
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); check_eq("b_first_strobe", 32'(b_count), 1);
                        check_eq("b_h_before", 32'(b_h), 0);
        @(negedge clk); check_eq("b_h_after", 32'(b_h), 1);

        fs_n = 0; strobes = 0; vbs_n = 0; vbs_h = -1; vbs_v = -1;
        vs_min = 9999; vs_max = 0; vs_err = 0;
        fs_pre_h = -1; fs_pre_v = -1; fs_h = -1; fs_v = -1;
        pf_p0 = 1'bx; pf_p1 = 1'bx; pf_n0 = 1'bx; pf_n1 = 1'bx; pf_n2 = 1'bx;
        prev_h = 32'(b_h); prev_v = 32'(b_v);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (b_fs) begin
                fs_n++;
                if (fs_n == 1) begin
                    fs_pre_h = prev_h; fs_pre_v = prev_v;
                    fs_h = 32'(b_h); fs_v = 32'(b_v);
                end else begin
                    break;
                end
            end
            if (fs_n == 1) begin
                if (b_count) strobes++;
                if (b_vbs) begin vbs_n++; vbs_h = 32'(b_h); vbs_v = 32'(b_v); end
                if (!b_vsync) begin
                    if (32'(b_v) < vs_min) vs_min = 32'(b_v);
                    if (32'(b_v) > vs_max) vs_max = 32'(b_v);
                end
                if (b_vsync !== !(b_v == 11'd14 || b_v == 11'd15)) vs_err++;
                if (b_h == 11'd4  && b_v == 11'd2)  pf_p0 = b_pf;
                if (b_h == 11'd11 && b_v == 11'd9)  pf_p1 = b_pf;
                if (b_h == 11'd3  && b_v == 11'd2)  pf_n0 = b_pf;
                if (b_h == 11'd12 && b_v == 11'd5)  pf_n1 = b_pf;
                if (b_h == 11'd6  && b_v == 11'd10) pf_n2 = b_pf;
            end
            prev_h = 32'(b_h); prev_v = 32'(b_v);
        end
        check_eq("b_fs_count", fs_n, 2);
        check_eq("b_fs_prev_h", fs_pre_h, 23);
        check_eq("b_fs_prev_v", fs_pre_v, 18);
        check_eq("b_fs_h", fs_h, 0);
        check_eq("b_fs_v", fs_v, 0);
        check_eq("b_frame_strobes", strobes, 456);
        check_eq("b_vbs_count", vbs_n, 1);
        check_eq("b_vbs_h", vbs_h, 0);
        check_eq("b_vbs_v", vbs_v, 12);
        check_eq("b_vsync_first_line", vs_min, 14);
        check_eq("b_vsync_last_line", vs_max, 15);
        check_eq("b_vsync_align_errs", vs_err, 0);
        check_eq("b_pf_x0y0", 32'(pf_p0), 1);
        check_eq("b_pf_x1m1y1m1", 32'(pf_p1), 1);
        check_eq("b_pf_x0m1", 32'(pf_n0), 0);
        check_eq("b_pf_x1", 32'(pf_n1), 0);
        check_eq("b_pf_y1", 32'(pf_n2), 0);

        // async reset inside the vsync lines
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (b_v == 11'd14) begin found = 1; break; end
        end
        check_eq("b_reach_vsync", found, 1);
        check_eq("b_vsync_low_pre", 32'(b_vsync), 0);
        #2 rst_b = 1'b0;
        #1;
        check_eq("b_async_vsync", 32'(b_vsync), 1);
        check_eq("b_async_blank", 32'(b_blank), 1);
        check_eq("b_async_h", 32'(b_h), 0);
        check_eq("b_async_v", 32'(b_v), 0);
        check_eq("b_async_count", 32'(b_count), 0);
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); check_eq("b_restart_strobe", 32'(b_count), 1);
                        check_eq("b_restart_h0", 32'(b_h), 0);
        @(negedge clk); check_eq("b_restart_h1", 32'(b_h), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
